// File: rtl/log2_pkg.sv
// log2_pkg: shared state encoding and parameter helpers for the iterative log2 unit.
package log2_pkg;
    typedef enum logic [1:0] {IDLE, NORM, ITER, DONE} state_t;

    function automatic int clog2_min(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++)
            if ((64'd1 << i) < 64'(n)) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/log2_lod.sv
// log2_lod: combinational leading-one detector, returns index of highest set bit and a zero flag.
module log2_lod #(
    parameter int IN_W = 5,
    parameter int IW   = $clog2(IN_W)
) (
    input  logic [IN_W-1:0] x,
    output logic [IW-1:0]   idx,
    output logic            zero
);
    always_comb begin
        idx = '0;
        for (int i = 0; i < IN_W; i++)
            if (x[i]) idx = IW'(i);
    end
    assign zero = (x == '0);
endmodule

// File: rtl/log2_fx_seq.sv
// log2_fx_seq: iterative fixed-point log2 with valid/ready handshakes.
// Integer part from leading-one position, fraction by repeated squaring of the normalised mantissa.
module log2_fx_seq
    import log2_pkg::*;
#(
    parameter int IN_W   = 5,
    parameter int FRAC_W = 5,
    parameter int INT_W  = 6,
    parameter int PREC   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IN_W-1:0]         x,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [INT_W+FRAC_W-1:0] y,
    output logic                    err
);
    localparam int IW    = $clog2(IN_W);
    localparam int CNT_W = $clog2(FRAC_W + 1);
    localparam int WW    = (IN_W > PREC + 1) ? IN_W : PREC + 1;

    if (INT_W < clog2_min(IN_W) || PREC < FRAC_W + 4) begin : g_bad_param
        $error("log2_fx_seq: INT_W or PREC too small for IN_W/FRAC_W");
    end

    state_t               state, state_nx;
    logic [IN_W-1:0]      xr;
    logic [PREC:0]        m, m_init, m_nx;
    logic [PREC+1:0]      s;
    logic [2*PREC+1:0]    sq;
    logic [WW-1:0]        wide;
    logic [CNT_W-1:0]     k;
    logic [INT_W-1:0]     ip;
    logic [FRAC_W-1:0]    fr;
    logic [IW-1:0]        p;
    logic                 zero;

    log2_lod #(.IN_W(IN_W), .IW(IW)) u_lod (.x(xr), .idx(p), .zero(zero));

    // Left-justify the operand so its leading one lands on the 1.PREC integer bit.
    assign wide   = WW'(xr << (IW'(IN_W - 1) - p)) << (WW - IN_W);
    assign m_init = (PREC + 1)'(wide >> (WW - PREC - 1));
    assign sq     = (2*PREC + 2)'(m) * (2*PREC + 2)'(m);
    assign s      = (PREC + 2)'(sq >> PREC);
    assign m_nx   = s[PREC+1] ? s[PREC+1:1] : s[PREC:0];

    assign in_ready = (state == IDLE);
    assign y        = {ip, fr};

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = in_valid ? NORM : IDLE;
            NORM:    state_nx = zero ? DONE : ITER;
            ITER:    state_nx = (k == CNT_W'(FRAC_W - 1)) ? DONE : ITER;
            DONE:    state_nx = (out_valid && out_ready) ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    // out_valid rises one cycle after entering DONE and falls on the handshake edge.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            xr        <= '0;
            m         <= '0;
            k         <= '0;
            ip        <= '0;
            fr        <= '0;
            err       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) xr <= x;
                NORM: begin
                    err <= zero;
                    ip  <= zero ? '0 : INT_W'(p);
                    fr  <= '0;
                    m   <= m_init;
                    k   <= '0;
                end
                ITER: begin
                    m  <= m_nx;
                    fr <= (fr << 1) | FRAC_W'(s[PREC+1]);
                    k  <= k + CNT_W'(1);
                end
                DONE: begin
                    out_valid <= !(out_valid && out_ready);
                    if (out_valid && out_ready) begin
                        ip  <= '0;
                        fr  <= '0;
                        err <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
endmodule

// File: tb/tb_log2_fx_seq.sv
// tb_log2_fx_seq: directed and randomised checks of log2_fx_seq against an arithmetic model.
module tb_log2_fx_seq;
    localparam int IN_W = 5, FRAC_W = 5, INT_W = 6, PREC = 16, YW = INT_W + FRAC_W;

    logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
    logic [IN_W-1:0] x = '0;
    logic in_ready, out_valid, err;
    logic [YW-1:0] y;
    int n_chk = 0, n_fail = 0;

    log2_fx_seq #(.IN_W(IN_W), .FRAC_W(FRAC_W), .INT_W(INT_W), .PREC(PREC)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x),
        .out_valid(out_valid), .out_ready(out_ready), .y(y), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Floor log2 from plain integer arithmetic: mantissa scaled by 2^PREC, squared and truncated.
    function automatic logic [YW-1:0] ref_log2(input int unsigned v);
        int p;
        longint m, s;
        logic [YW-1:0] r;
        if (v == 0) return '0;
        p = 0;
        for (int i = 0; i < IN_W; i++) if ((v >> i) != 0) p = i;
        m = (longint'(v) << PREC) >> p;
        r = YW'(p) << FRAC_W;
        for (int b = FRAC_W - 1; b >= 0; b--) begin
            s = (m * m) >> PREC;
            if (s >= (longint'(2) << PREC)) begin
                r[b] = 1'b1;
                m = s >> 1;
            end else m = s;
        end
        return r;
    endfunction

    task automatic run_op(input logic [IN_W-1:0] v, input int stall, output logic [YW-1:0] got_y);
        int lat;
        logic [YW-1:0] exp_y;
        exp_y = ref_log2(v);
        @(negedge clk);
        check("idle_in_ready", in_ready, 1);
        x = v;
        in_valid = 1;
        out_ready = (stall == 0);
        @(posedge clk); #1;
        in_valid = 0;
        x = IN_W'($urandom);
        lat = 0;
        while (!out_valid && lat < 40) begin
            check("busy_in_ready", in_ready, 0);
            in_valid = $urandom_range(0, 1);
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 0;
        check("latency", lat, (v == 0) ? 2 : FRAC_W + 2);
        check("y", y, exp_y);
        check("err", err, v == 0);
        got_y = y;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check("stall_valid", out_valid, 1);
            check("stall_y", y, exp_y);
            check("stall_in_ready", in_ready, 0);
        end
        out_ready = 1;
        @(posedge clk); #1;
        check("post_valid", out_valid, 0);
        check("post_y", y, 0);
        check("post_err", err, 0);
        check("post_in_ready", in_ready, 1);
        out_ready = 0;
    endtask

    initial begin
        logic [YW-1:0] gy;
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_y", y, 0);
        check("rst_err", err, 0);
        @(negedge clk); rst = 0;

        run_op(5'd15, 0, gy); check("x15", gy, 125);
        run_op(5'd14, 0, gy); check("x14", gy, 121);
        run_op(5'd8, 0, gy);  check("x8", gy, 96);
        run_op(5'd1, 0, gy);  check("x1", gy, 0);
        run_op(5'd0, 0, gy);  check("x0", gy, 0);
        run_op(5'd16, 0, gy); check("x16", gy, 128);
        run_op(5'd31, 0, gy); check("x31_int", gy >> FRAC_W, 4);
        run_op(5'd15, 10, gy); check("x15_stall", gy, 125);

        // Abort mid-iteration with an asynchronous reset pulse.
        @(negedge clk);
        x = 5'd15; in_valid = 1; out_ready = 1;
        @(posedge clk); #1; in_valid = 0;
        repeat (3) @(posedge clk);
        #2 rst = 1;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_y", y, 0);
        @(negedge clk); rst = 0; out_ready = 0;
        run_op(5'd14, 0, gy); check("x14_after_abort", gy, 121);

        for (int i = 0; i < 40; i++) run_op(IN_W'($urandom), $urandom_range(0, 3), gy);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
